// File: rtl/idex_stage_reg_pkg.sv
// Shared pipeline definitions: control-bundle layout and register-number constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package idex_stage_reg_pkg;

    // Control bundle {regwrite,memread,memwrite,memtoreg,alusrc,regdst,branch,aluop[1:0]}
    localparam int CTRL_W        = 9;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP    = 0;

    // A bubble carries no side effects: no regwrite, memread or memwrite.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 9'b0;

    // Register 0 is hardwired zero, so it never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/idex_stage_reg_if.sv
// ID-to-EX bundle: decoded fields in, registered fields, stall and stall count out.
// Latency: n/a (wires only).
// Backpressure: stall is driven back to the ID side, which holds its fields while high.
interface idex_stage_reg_if
    import idex_stage_reg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
);
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [WIDTH-1:0]  id_rdata1;
    logic [WIDTH-1:0]  id_rdata2;
    logic [WIDTH-1:0]  id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush;
    logic              stall;
    logic              idex_valid;
    logic [4:0]        idex_rs;
    logic [4:0]        idex_rt;
    logic [4:0]        idex_rd;
    logic [WIDTH-1:0]  idex_rdata1;
    logic [WIDTH-1:0]  idex_rdata2;
    logic [WIDTH-1:0]  idex_imm;
    logic [CTRL_W-1:0] idex_ctrl;
    logic [CNTW-1:0]   stallcnt;

    // ID stage / hazard controller side
    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl, flush,
        input  stall, idex_valid, idex_rs, idex_rt, idex_rd,
               idex_rdata1, idex_rdata2, idex_imm, idex_ctrl, stallcnt
    );

    // Pipeline register side
    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl, flush,
        output stall, idex_valid, idex_rs, idex_rt, idex_rd,
               idex_rdata1, idex_rdata2, idex_imm, idex_ctrl, stallcnt
    );

endinterface

// File: rtl/idex_stage_reg_load_use_detect.sv
// Load-use hazard: a valid load in EX writes a register that the valid instruction in ID reads.
// Latency: combinational.
// Backpressure: none; the caller turns the hazard into a stall.
module load_use_detect
    import idex_stage_reg_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    // A load targeting r0 never produces a usable value, so it cannot cause a dependency.
    assign hazard = ex_valid & ex_memread & (ex_rt != REG_ZERO) & id_valid &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and stall counter.
// Latency: one cycle from ID fields to idex_* outputs; stall is combinational.
// Backpressure: stall asks upstream to freeze PC and IF/ID for one cycle while a bubble enters EX.
module idex_stage_reg
    import idex_stage_reg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
)(
    input logic          clk,
    input logic          rst_n,
    idex_stage_reg_if.slave bus
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic hazard;
    logic take_bubble;

    load_use_detect u_detect (
        .ex_valid   (bus.idex_valid),
        .ex_memread (bus.idex_ctrl[CTRL_MEMREAD]),
        .ex_rt      (bus.idex_rt),
        .id_valid   (bus.id_valid),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .hazard     (hazard)
    );

    // A flush discards the ID instruction anyway, so it overrides the stall request.
    assign bus.stall   = hazard & ~bus.flush & rst_n;
    assign take_bubble = bus.flush | bus.stall;

    // Pipeline register: bubble on flush or stall, otherwise capture ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.idex_valid  <= 1'b0;
            bus.idex_rs     <= REG_ZERO;
            bus.idex_rt     <= REG_ZERO;
            bus.idex_rd     <= REG_ZERO;
            bus.idex_rdata1 <= {WIDTH{1'b0}};
            bus.idex_rdata2 <= {WIDTH{1'b0}};
            bus.idex_imm    <= {WIDTH{1'b0}};
            bus.idex_ctrl   <= CTRL_BUBBLE;
        end else if (take_bubble) begin
            // Zeroed register numbers keep the forwarding unit from matching on a bubble.
            bus.idex_valid  <= 1'b0;
            bus.idex_rs     <= REG_ZERO;
            bus.idex_rt     <= REG_ZERO;
            bus.idex_rd     <= REG_ZERO;
            bus.idex_rdata1 <= {WIDTH{1'b0}};
            bus.idex_rdata2 <= {WIDTH{1'b0}};
            bus.idex_imm    <= {WIDTH{1'b0}};
            bus.idex_ctrl   <= CTRL_BUBBLE;
        end else begin
            bus.idex_valid  <= bus.id_valid;
            bus.idex_rs     <= bus.id_rs;
            bus.idex_rt     <= bus.id_rt;
            bus.idex_rd     <= bus.id_rd;
            bus.idex_rdata1 <= bus.id_rdata1;
            bus.idex_rdata2 <= bus.id_rdata2;
            bus.idex_imm    <= bus.id_imm;
            bus.idex_ctrl   <= bus.id_ctrl;
        end
    end

    // Saturating count of stalled cycles; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.stallcnt <= {CNTW{1'b0}};
        end else if (bus.stall && (bus.stallcnt != CNT_MAX)) begin
            bus.stallcnt <= bus.stallcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: directed hazard scenarios plus random traffic against a slot model.
// Two instances share stimulus: a 16-bit counter and a 2-bit counter for saturation.
// Outputs are sampled at the falling edge; stall is sampled 1ns after inputs change.
module tb_idex_stage_reg;
    import idex_stage_reg_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    idex_stage_reg_if #(.WIDTH(W), .CNTW(16)) ifa ();
    idex_stage_reg_if #(.WIDTH(W), .CNTW(2))  ifb ();

    idex_stage_reg #(.WIDTH(W), .CNTW(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    idex_stage_reg #(.WIDTH(W), .CNTW(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    assign ifb.id_valid  = ifa.id_valid;
    assign ifb.id_rs     = ifa.id_rs;
    assign ifb.id_rt     = ifa.id_rt;
    assign ifb.id_rd     = ifa.id_rd;
    assign ifb.id_rdata1 = ifa.id_rdata1;
    assign ifb.id_rdata2 = ifa.id_rdata2;
    assign ifb.id_imm    = ifa.id_imm;
    assign ifb.id_ctrl   = ifa.id_ctrl;
    assign ifb.flush     = ifa.flush;

    localparam logic [8:0] C_ADD = 9'b1_0000_1010;  // regwrite, regdst, aluop=10
    localparam logic [8:0] C_LW  = 9'b1_1011_0000;  // regwrite, memread, memtoreg, alusrc

    // Reference model: what instruction EX holds, and how many stalls have happened.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [8:0]  ctrl;
    } slot_t;

    slot_t ex;
    int    n_stalls;
    logic  last_stall;
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // A load in EX stalls a valid ID instruction that reads its (nonzero) destination.
    function automatic logic model_stall();
        if (!rst_n || ifa.flush || !ifa.id_valid) return 1'b0;
        if (!ex.valid || !ex.ctrl[CTRL_MEMREAD] || ex.rt == 5'd0) return 1'b0;
        return (ex.rt == ifa.id_rs) || (ex.rt == ifa.id_rt);
    endfunction

    task automatic model_edge(input logic s);
        if (ifa.flush || s) ex = '0;
        else ex = '{ifa.id_valid, ifa.id_rs, ifa.id_rt, ifa.id_rd,
                    ifa.id_rdata1, ifa.id_rdata2, ifa.id_imm, ifa.id_ctrl};
        if (s) n_stalls++;
    endtask

    task automatic check_outputs();
        chk("valid",  ifa.idex_valid,  ex.valid);
        chk("rs",     ifa.idex_rs,     ex.rs);
        chk("rt",     ifa.idex_rt,     ex.rt);
        chk("rd",     ifa.idex_rd,     ex.rd);
        chk("rdata1", ifa.idex_rdata1, ex.d1);
        chk("rdata2", ifa.idex_rdata2, ex.d2);
        chk("imm",    ifa.idex_imm,    ex.imm);
        chk("ctrl",   ifa.idex_ctrl,   ex.ctrl);
        chk("cnt16",  ifa.stallcnt,    (n_stalls > 65535) ? 65535 : n_stalls);
        chk("cnt2",   ifb.stallcnt,    (n_stalls > 3) ? 3 : n_stalls);
        chk("ctrl_b", ifb.idex_ctrl,   ex.ctrl);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [8:0] c, input logic f);
        ifa.id_valid  = v;
        ifa.id_rs     = rs;
        ifa.id_rt     = rt;
        ifa.id_rd     = rd;
        ifa.id_rdata1 = $urandom;
        ifa.id_rdata2 = $urandom;
        ifa.id_imm    = $urandom;
        ifa.id_ctrl   = c;
        ifa.flush     = f;
    endtask

    task automatic drive_random();
        drive(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom), 9'($urandom), ($urandom_range(0, 9) == 0));
    endtask

    // One clock: check combinational stall, clock the model, check registered outputs.
    task automatic cycle();
        logic s;
        #1;
        s = model_stall();
        chk("stall",   ifa.stall, s);
        chk("stall_b", ifb.stall, s);
        @(posedge clk);
        model_edge(s);
        last_stall = s;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_random();
        ex = '0;
        n_stalls = 0;
        last_stall = 1'b0;
        #1;
        check_outputs();
        chk("rst_stall", ifa.stall, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b0, 5'd0, 5'd0, 5'd0, 9'd0, 1'b0);
        @(negedge clk);
        apply_reset();

        // Pass-through of a plain ALU op
        drive(1'b1, 5'd3, 5'd4, 5'd5, C_ADD & 9'h100, 1'b0);
        ifa.id_rdata1 = 32'h1234;
        cycle();
        chk("pt_rs", ifa.idex_rs, 5'd3);
        chk("pt_rt", ifa.idex_rt, 5'd4);
        chk("pt_d1", ifa.idex_rdata1, 32'h1234);

        // Load-use: lw r8 then add reading r8
        drive(1'b1, 5'd1, 5'd8, 5'd0, C_LW, 1'b0);
        cycle();
        drive(1'b1, 5'd8, 5'd2, 5'd9, C_ADD, 1'b0);
        #1 chk("lu_stall", ifa.stall, 1'b1);
        cycle();
        chk("lu_bubble", ifa.idex_ctrl, 9'd0);
        cycle();
        chk("lu_loaded", ifa.idex_rs, 5'd8);
        chk("lu_cnt", ifa.stallcnt, 16'd1);

        // No false hazard: load into r0, and a non-load writing r8
        drive(1'b1, 5'd1, 5'd0, 5'd0, C_LW, 1'b0);
        cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd3, C_ADD, 1'b0);
        #1 chk("r0_nostall", ifa.stall, 1'b0);
        cycle();
        drive(1'b1, 5'd1, 5'd8, 5'd8, C_ADD, 1'b0);
        cycle();
        drive(1'b1, 5'd8, 5'd8, 5'd3, C_ADD, 1'b0);
        #1 chk("alu_nostall", ifa.stall, 1'b0);
        cycle();

        // Flush and hazard together: flush wins
        drive(1'b1, 5'd1, 5'd8, 5'd0, C_LW, 1'b0);
        cycle();
        drive(1'b1, 5'd8, 5'd2, 5'd9, C_ADD, 1'b1);
        #1 chk("fl_stall", ifa.stall, 1'b0);
        cycle();
        chk("fl_bubble", ifa.idex_valid, 1'b0);
        chk("fl_cnt", ifa.stallcnt, 16'd1);

        // Reset in the middle of a stall, then normal load after release
        drive(1'b1, 5'd1, 5'd8, 5'd0, C_LW, 1'b0);
        ifa.flush = 1'b0;
        cycle();
        drive(1'b1, 5'd8, 5'd2, 5'd9, C_ADD, 1'b0);
        #1 chk("ms_stall", ifa.stall, 1'b1);
        rst_n = 1'b0;
        ex = '0;
        n_stalls = 0;
        #1;
        check_outputs();
        chk("ms_stall_rst", ifa.stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("ms_loaded", ifa.idex_rs, 5'd8);

        // Saturation: five load-use pairs
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd1, 5'd8, 5'd0, C_LW, 1'b0);
            cycle();
            drive(1'b1, 5'd8, 5'd2, 5'd9, C_ADD, 1'b0);
            cycle();
            cycle();
        end
        chk("sat_b", ifb.stallcnt, 2'd3);
        chk("sat_a", ifa.stallcnt, 16'd5);

        // Random traffic; upstream holds ID while stalled
        for (int i = 0; i < 400; i++) begin
            if (last_stall) ifa.flush = ($urandom_range(0, 9) == 0);
            else drive_random();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
